// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver (8 data bits MSB-first, start/stop framing) that
// assembles NUM_BYTES consecutive bytes into one wide frame vector.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           asynchronous serial line, idle high
//   out_data     assembled frame, first received bit at MSB
//   done         one-cycle pulse, cycle after the last byte of a frame lands
//   frame_valid  out_data holds a complete frame
//   busy         receiver not idle
//   frame_err    one-cycle pulse, stop bit sampled low
//   timeout      one-cycle pulse, partial frame dropped after idle time
//   byte_cnt     bytes accepted in the current frame
//
// Optional build macro RX_TIMEOUT_EN: when defined, a partial frame is
// discarded after TIMEOUT_BITS idle bit-times. When undefined, timeout is 0.
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned NUM_BYTES    = 784,
   parameter int unsigned TIMEOUT_BITS = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rx,
   output logic [NUM_BYTES*8-1:0]       out_data,
   output logic                         done,
   output logic                         frame_valid,
   output logic                         busy,
   output logic                         frame_err,
   output logic                         timeout,
   output logic [$clog2(NUM_BYTES)-1:0] byte_cnt
);

   localparam int unsigned DATA_W  = NUM_BYTES * 8;
   localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
   localparam int unsigned BC_W    = $clog2(NUM_BYTES);
   localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
   localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HI
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic             r_rx_meta, r_rx_sync, r_rx_prev;
   logic             r_last_acc;
   logic             w_accept, w_ferr, w_last, w_tmo;

   assign w_last = (byte_cnt == BC_W'(NUM_BYTES - 1));

   // Next-state and per-bit sampling decisions
   always_comb begin
      w_state_nxt   = r_state;
      w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
      w_bit_cnt_nxt = r_bit_cnt;
      w_byte_nxt    = r_byte;
      w_accept      = 1'b0;
      w_ferr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_clk_cnt_nxt = '0;
            if (r_rx_prev && !r_rx_sync) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_clk_cnt == CNT_W'(HALF_M1)) begin
               w_clk_cnt_nxt = '0;
               // line back high at mid-start: treat as a glitch
               w_state_nxt   = r_rx_sync ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_clk_cnt == CNT_W'(FULL_M1)) begin
               w_clk_cnt_nxt = '0;
               w_byte_nxt    = {r_byte[6:0], r_rx_sync};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (r_clk_cnt == CNT_W'(FULL_M1)) begin
               w_clk_cnt_nxt = '0;
               if (r_rx_sync) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_WAIT_HI;
               end
            end
         end
         S_WAIT_HI: begin
            // a low stop bit must not be mistaken for the next start edge
            w_clk_cnt_nxt = '0;
            if (r_rx_sync) w_state_nxt = S_IDLE;
         end
         default: begin
            w_clk_cnt_nxt = '0;
            w_state_nxt   = S_IDLE;
         end
      endcase
   end

   // State, synchroniser and bit-level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_byte    <= '0;
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_byte    <= w_byte_nxt;
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

`ifdef RX_TIMEOUT_EN
   localparam int unsigned TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W   = $clog2(TMO_CYC);

   logic [TMO_W-1:0] r_idle_cnt;

   assign w_tmo = (r_state == S_IDLE) && (byte_cnt != '0) &&
                  (r_idle_cnt == TMO_W'(TMO_CYC - 1));

   // Idle time counted only while a partial frame is pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idle_cnt <= '0;
      end else if ((r_state != S_IDLE) || (byte_cnt == '0) || w_tmo) begin
         r_idle_cnt <= '0;
      end else begin
         r_idle_cnt <= r_idle_cnt + TMO_W'(1);
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // Frame assembly and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data    <= '0;
         done        <= 1'b0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         frame_err   <= 1'b0;
         timeout     <= 1'b0;
         byte_cnt    <= '0;
         r_last_acc  <= 1'b0;
      end else begin
         busy       <= (w_state_nxt != S_IDLE);
         frame_err  <= w_ferr;
         timeout    <= w_tmo;
         r_last_acc <= w_accept && w_last;
         done       <= r_last_acc;
         if (w_accept) begin
            out_data <= {out_data[DATA_W-9:0], r_byte};
            if (w_last) begin
               byte_cnt    <= '0;
               frame_valid <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + BC_W'(1);
               if (byte_cnt == '0) frame_valid <= 1'b0;
            end
         end else if (w_tmo) begin
            byte_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed scenarios followed by random frames,
// checked against a byte-level model of the frame assembler.
module tb_uart_rx_frame;

   localparam int CPB = 16;
   localparam int NB  = 4;
   localparam int TBT = 16;
   localparam int TMO = TBT * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] out_data;
   logic        done, frame_valid, busy, frame_err, timeout;
   logic [1:0]  byte_cnt;

   uart_rx_frame #(
      .CLKS_PER_BIT(CPB),
      .NUM_BYTES   (NB),
      .TIMEOUT_BITS(TBT)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .out_data   (out_data),
      .done       (done),
      .frame_valid(frame_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .timeout    (timeout),
      .byte_cnt   (byte_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: bytes accepted so far, frame state, expected pulse counts
   logic [31:0] m_shift = '0;
   int          m_cnt = 0;
   bit          m_fv = 1'b0;
   int          exp_done = 0;
   int          exp_ferr = 0;
   int          exp_tmo = 0;

   // pulse monitor
   int cyc = 0;
   int n_done = 0, n_done_bad = 0, n_ferr = 0, n_tmo = 0;
   int t_tmo = 0, t_acc = 0;
   bit fv_d1 = 1'b0, fv_d2 = 1'b0, done_d1 = 1'b0;
   logic [1:0] bc_d1 = '0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (done) begin
         n_done = n_done + 1;
         if (!(fv_d1 && !fv_d2 && !done_d1)) n_done_bad = n_done_bad + 1;
      end
      if (frame_err) n_ferr = n_ferr + 1;
      if (timeout) begin
         n_tmo = n_tmo + 1;
         t_tmo = cyc;
      end
      if ((byte_cnt != bc_d1) && (byte_cnt != 2'd0)) t_acc = cyc;
      bc_d1   = byte_cnt;
      fv_d2   = fv_d1;
      fv_d1   = frame_valid;
      done_d1 = done;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check_val({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(m_cnt));
      check_val({tag, "_frame_valid"}, 64'(frame_valid), 64'(m_fv));
      check_val({tag, "_done_cnt"}, 64'(n_done), 64'(exp_done));
      check_val({tag, "_ferr_cnt"}, 64'(n_ferr), 64'(exp_ferr));
      if (m_fv) check_val({tag, "_out_data"}, 64'(out_data), 64'(m_shift));
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // one character; a bad stop is followed by one high bit so the line recovers
   task automatic send_byte(input logic [7:0] b, input int nstop, input bit stop_ok);
      send_bit(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      for (int i = 0; i < nstop; i++) send_bit(stop_ok);
      if (!stop_ok) send_bit(1'b1);
      if (stop_ok) begin
         m_shift = {m_shift[23:0], b};
         if (m_cnt == 0) m_fv = 1'b0;
         m_cnt = m_cnt + 1;
         if (m_cnt == NB) begin
            m_cnt    = 0;
            m_fv     = 1'b1;
            exp_done = exp_done + 1;
         end
      end else begin
         exp_ferr = exp_ferr + 1;
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] f1 [4];
      logic [7:0] b;
      f1 = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_out_data", 64'(out_data), 64'h0);
      check_val("rst_done", 64'(done), 64'h0);
      check_val("rst_frame_valid", 64'(frame_valid), 64'h0);
      check_val("rst_busy", 64'(busy), 64'h0);
      check_val("rst_frame_err", 64'(frame_err), 64'h0);
      check_val("rst_timeout", 64'(timeout), 64'h0);
      check_val("rst_byte_cnt", 64'(byte_cnt), 64'h0);
      rst_n = 1'b1;
      idle(2 * CPB);

      // 8N2 frame
      for (int i = 0; i < 4; i++) begin
         send_byte(f1[i], 2, 1'b1);
         check_state("f1");
      end
      check_val("f1_frame", 64'(out_data), 64'hA53C0FF0);
      idle(CPB);

      // back-to-back with a single stop bit
      for (int i = 1; i <= 4; i++) begin
         send_byte(8'(i), 1, 1'b1);
         check_state("f2");
      end
      check_val("f2_frame", 64'(out_data), 64'h01020304);
      idle(2 * CPB);

      // start-bit glitch in IDLE with a byte pending
      send_byte(8'h77, 2, 1'b1);
      check_state("g_pre");
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      check_val("glitch_busy_hi", 64'(busy), 64'h1);
      repeat (20) @(negedge clk);
      check_val("glitch_busy_lo", 64'(busy), 64'h0);
      check_state("glitch");

      // stop bit forced low, then a good byte
      send_byte(8'h55, 2, 1'b0);
      check_state("ferr");
      send_byte(8'h66, 2, 1'b1);
      check_state("ferr_next");
      send_byte(8'h88, 1, 1'b1);
      send_byte(8'h99, 1, 1'b1);
      check_state("ferr_frame");
      check_val("ferr_frame_data", 64'(out_data), 64'h77668899);
      idle(CPB);

      // reset during third data bit of the second byte
      send_byte(8'h11, 2, 1'b1);
      b = 8'h22;
      send_bit(1'b0);
      send_bit(b[7]);
      send_bit(b[6]);
      rx = b[5];
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("mid_rst_out_data", 64'(out_data), 64'h0);
      check_val("mid_rst_frame_valid", 64'(frame_valid), 64'h0);
      check_val("mid_rst_busy", 64'(busy), 64'h0);
      check_val("mid_rst_byte_cnt", 64'(byte_cnt), 64'h0);
      check_val("mid_rst_done", 64'(done), 64'h0);
      check_val("mid_rst_ferr", 64'(frame_err), 64'h0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      m_shift = '0;
      m_cnt   = 0;
      m_fv    = 1'b0;
      idle(2 * CPB);
      send_byte(8'h11, 2, 1'b1);
      send_byte(8'h22, 2, 1'b1);
      send_byte(8'h33, 2, 1'b1);
      send_byte(8'h44, 2, 1'b1);
      check_state("post_rst");
      check_val("post_rst_frame", 64'(out_data), 64'h11223344);

      // partial frame left idle
      send_byte(8'hDE, 2, 1'b1);
      send_byte(8'hAD, 2, 1'b1);
      idle(TMO + 32);
`ifdef RX_TIMEOUT_EN
      m_cnt   = 0;
      exp_tmo = exp_tmo + 1;
      check_val("tmo_latency", 64'(t_tmo - t_acc), 64'(TMO));
`endif
      check_val("tmo_cnt", 64'(n_tmo), 64'(exp_tmo));
      check_state("tmo");
      for (int i = 0; i < 4; i++) begin
         send_byte(8'($urandom), 2, 1'b1);
         check_state("tmo_next");
      end

      // random traffic: stop count, gaps and occasional bad stop bits
      for (int i = 0; i < 24; i++) begin
         send_byte(8'($urandom), 1 + int'($urandom_range(1, 0)), ($urandom_range(7, 0) != 0));
         check_state("rand");
         idle(int'($urandom_range(20, 0)));
      end

      check_val("done_timing", 64'(n_done_bad), 64'h0);
      check_val("tmo_total", 64'(n_tmo), 64'(exp_tmo));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
